// File: rtl/riscv_pkg.sv
// Shared RISC-V constants: datapath and register-address widths,
// load/store funct3 encodings and access-size codes.
package riscv_pkg;

    localparam int unsigned XLEN       = 32;
    localparam int unsigned REG_ADDR_W = 5;

    typedef enum logic [2:0] {
        F3_B  = 3'b000,
        F3_H  = 3'b001,
        F3_W  = 3'b010,
        F3_BU = 3'b100,
        F3_HU = 3'b101
    } funct3_e;

    // Access size lives in funct3[1:0] for both loads and stores.
    typedef enum logic [1:0] {
        SZ_B = 2'b00,
        SZ_H = 2'b01,
        SZ_W = 2'b10
    } mem_size_e;

    localparam logic [1:0] RESULT_MEM = 2'b01;

endpackage

// File: rtl/data_mem.sv
// Little-endian byte-array data memory: byte-enable synchronous write,
// combinational 4-byte read. Contents are never reset.
module data_mem #(
    parameter int unsigned ADDR_WIDTH = 12
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [3:0]            be,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [31:0]           wdata,
    output logic [31:0]           rdata
);

    logic [7:0] mem [0:(1 << ADDR_WIDTH) - 1];

    // Lane i maps to byte addr+i; the address wraps at the top of memory.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem[addr + ADDR_WIDTH'(i)] <= wdata[8*i +: 8];
                end
            end
        end
    end

    always_comb begin
        rdata = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            rdata[8*i +: 8] = mem[addr + ADDR_WIDTH'(i)];
        end
    end

endmodule

// File: rtl/memory_stage.sv
// Pipeline memory stage: E->M register, store byte enables, misalign
// detection and load extension around the data_mem byte array.
module memory_stage
    import riscv_pkg::*;
#(
    parameter int unsigned WIDTH      = XLEN,
    parameter int unsigned ADDR_WIDTH = 12
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  StallM,
    input  logic                  FlushM,
    input  logic                  RegWriteE,
    input  logic [1:0]            ResultSrcE,
    input  logic                  MemWriteE,
    input  logic [2:0]            Funct3E,
    input  logic [WIDTH-1:0]      ALUResultE,
    input  logic [WIDTH-1:0]      WriteDataE,
    input  logic [WIDTH-1:0]      PCPlus4E,
    input  logic [REG_ADDR_W-1:0] RdE,
    output logic                  RegWriteM,
    output logic [1:0]            ResultSrcM,
    output logic [REG_ADDR_W-1:0] RdM,
    output logic [WIDTH-1:0]      ALUResultM,
    output logic [WIDTH-1:0]      PCPlus4M,
    output logic [WIDTH-1:0]      ReadDataM,
    output logic                  MisalignM
);

    logic                  reg_write_q,  reg_write_d;
    logic [1:0]            result_src_q, result_src_d;
    logic                  mem_write_q,  mem_write_d;
    logic [2:0]            funct3_q,     funct3_d;
    logic [REG_ADDR_W-1:0] rd_q,         rd_d;
    logic [WIDTH-1:0]      alu_result_q, alu_result_d;
    logic [WIDTH-1:0]      write_data_q, write_data_d;
    logic [WIDTH-1:0]      pc_plus4_q,   pc_plus4_d;

    logic [ADDR_WIDTH-1:0] addr;
    logic                  access;
    logic                  misalign;
    logic [3:0]            be;
    logic                  we;
    logic [31:0]           rdata;

    always_comb begin
        reg_write_d  = reg_write_q;
        result_src_d = result_src_q;
        mem_write_d  = mem_write_q;
        funct3_d     = funct3_q;
        rd_d         = rd_q;
        alu_result_d = alu_result_q;
        write_data_d = write_data_q;
        pc_plus4_d   = pc_plus4_q;
        if (FlushM) begin
            reg_write_d  = 1'b0;
            result_src_d = '0;
            mem_write_d  = 1'b0;
            funct3_d     = '0;
            rd_d         = '0;
            alu_result_d = '0;
            write_data_d = '0;
            pc_plus4_d   = '0;
        end else if (!StallM) begin
            reg_write_d  = RegWriteE;
            result_src_d = ResultSrcE;
            mem_write_d  = MemWriteE;
            funct3_d     = Funct3E;
            rd_d         = RdE;
            alu_result_d = ALUResultE;
            write_data_d = WriteDataE;
            pc_plus4_d   = PCPlus4E;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reg_write_q  <= 1'b0;
            result_src_q <= '0;
            mem_write_q  <= 1'b0;
            funct3_q     <= '0;
            rd_q         <= '0;
            alu_result_q <= '0;
            write_data_q <= '0;
            pc_plus4_q   <= '0;
        end else begin
            reg_write_q  <= reg_write_d;
            result_src_q <= result_src_d;
            mem_write_q  <= mem_write_d;
            funct3_q     <= funct3_d;
            rd_q         <= rd_d;
            alu_result_q <= alu_result_d;
            write_data_q <= write_data_d;
            pc_plus4_q   <= pc_plus4_d;
        end
    end

    assign addr   = alu_result_q[ADDR_WIDTH-1:0];
    assign access = mem_write_q || (result_src_q == RESULT_MEM);

    always_comb begin
        misalign = 1'b0;
        be       = 4'b0000;
        case (funct3_q[1:0])
            SZ_B: be = 4'b0001;
            SZ_H: begin
                be       = 4'b0011;
                misalign = access && addr[0];
            end
            SZ_W: begin
                be       = 4'b1111;
                misalign = access && (addr[1:0] != 2'b00);
            end
            default: be = 4'b0000;
        endcase
    end

    // rst_n gating keeps a write from landing on an edge while reset is held.
    assign we = mem_write_q && !misalign && !StallM && rst_n;

    data_mem #(
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_data_mem (
        .clk  (clk),
        .we   (we),
        .be   (be),
        .addr (addr),
        .wdata(write_data_q[31:0]),
        .rdata(rdata)
    );

    always_comb begin
        ReadDataM = '0;
        if (access && !misalign) begin
            case (funct3_q)
                F3_B:    ReadDataM = WIDTH'($signed(rdata[7:0]));
                F3_H:    ReadDataM = WIDTH'($signed(rdata[15:0]));
                F3_W:    ReadDataM = WIDTH'(rdata);
                F3_BU:   ReadDataM = WIDTH'(rdata[7:0]);
                F3_HU:   ReadDataM = WIDTH'(rdata[15:0]);
                default: ReadDataM = '0;
            endcase
        end
    end

    assign RegWriteM  = reg_write_q;
    assign ResultSrcM = result_src_q;
    assign RdM        = rd_q;
    assign ALUResultM = alu_result_q;
    assign PCPlus4M   = pc_plus4_q;
    assign MisalignM  = misalign;

endmodule

// File: doc/memory_stage.md
MEMORY_STAGE -- requirements
Module: memory_stage

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, as the datapath width in bits.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 12, as the log2 of the data memory size in bytes.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock, rising-edge active.
REQ-004 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-005 The block SHALL have port StallM, input, 1 bit: hold the execute-to-memory register.
REQ-006 The block SHALL have port FlushM, input, 1 bit: load a bubble into the execute-to-memory register.
REQ-007 The block SHALL have ports RegWriteE (1), ResultSrcE (2), MemWriteE (1), all inputs: control from execute.
REQ-008 The block SHALL have port Funct3E, input, 3 bits: access size and sign (LB/LH/LW/LBU/LHU/SB/SH/SW encodings).
REQ-009 The block SHALL have ports ALUResultE, WriteDataE and PCPlus4E, all inputs, WIDTH bits each; and port RdE, input, 5 bits.
REQ-010 The block SHALL have ports RegWriteM (1), ResultSrcM (2), RdM (5), ALUResultM (WIDTH) and PCPlus4M (WIDTH), all outputs: registered values to writeback and forwarding.
REQ-011 The block SHALL have port ReadDataM, output, WIDTH bits: load data, already extended.
REQ-012 The block SHALL have port MisalignM, output, 1 bit: the current access is misaligned.

Function
REQ-013 On each rising clk edge with FlushM=1, the E->M register SHALL load all control fields as 0, RdM=0 and data fields as 0, regardless of StallM.
REQ-014 On each rising clk edge with FlushM=0 and StallM=1, the E->M register SHALL hold every field.
REQ-015 On each rising clk edge with FlushM=0 and StallM=0, every field SHALL be captured from its E-suffixed input (one-cycle latency).
REQ-016 Memory address SHALL be ALUResultM[ADDR_WIDTH-1:0]; upper bits are ignored, so the address wraps modulo 2^ADDR_WIDTH.
REQ-017 Memory SHALL be byte-addressed and little-endian.
REQ-018 Reads SHALL be combinational from the registered address.
REQ-019 Writes SHALL be synchronous at a rising clk edge while MemWriteM=1, MisalignM=0 and StallM=0.
REQ-020 Store width SHALL be: SB writes WriteDataM[7:0]; SH writes [15:0]; SW writes [31:0]; unaffected bytes are unchanged.
REQ-021 Load extension SHALL be: LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word unchanged.
REQ-022 MisalignM SHALL be 1 when a halfword access has addr[0]=1 or a word access has addr[1:0]!=0, and 0 for byte accesses and for cycles with no memory access.
REQ-023 While MisalignM=1, the store SHALL be suppressed and ReadDataM SHALL be 0.
REQ-024 A load issued in the cycle after a store to the same address SHALL return the newly written data.
REQ-025 ReadDataM SHALL be 0 when ResultSrcM!=2'b01 and MemWriteM=0.

Reset
REQ-026 While rst_n=0, all E->M register fields SHALL be 0 immediately, without waiting for clk.
REQ-027 As a consequence of REQ-026, RegWriteM=0, MemWriteM=0, RdM=0 and MisalignM=0 during reset.
REQ-028 Memory contents SHALL NOT be reset.
REQ-029 Assertion of rst_n mid-store SHALL abort the pending write.
REQ-030 The first capture after reset SHALL occur on the first rising clk edge with rst_n=1.

Structure
REQ-031 Constants WIDTH and register-address width, plus the Funct3 load/store encodings, SHALL reside in a shared package, riscv_pkg.
REQ-032 The byte-array memory with byte-enable write and combinational read SHALL be a sub-module, data_mem.
REQ-033 The E->M register, store byte-enable generation, load extension and misalign check SHALL reside in memory_stage.

Verification
REQ-034 The bench SHALL cover: SW 0xDEADBEEF to address 0x10, then LW at 0x10 -> ReadDataM=0xDEADBEEF on the following cycle.
REQ-035 The bench SHALL cover: SB 0x80 to address 0x13, then LB at 0x13 -> 0xFFFFFF80, and LBU at 0x13 -> 0x00000080; bytes 0x10-0x12 unchanged.
REQ-036 The bench SHALL cover: SH at address 0x21 -> MisalignM=1 and memory unchanged; LW at address 0x22 -> MisalignM=1 and ReadDataM=0.
REQ-037 The bench SHALL cover: StallM=1 for 3 cycles with changing E inputs -> M outputs frozen; FlushM=1 together with StallM=1 -> RegWriteM=0 and RdM=0 next edge.
REQ-038 The bench SHALL cover: ALUResultE=0x0000_1010 with ADDR_WIDTH=12 -> the access hits byte address 0x010.
REQ-039 The bench SHALL cover: rst_n pulled low mid-cycle during SW -> outputs 0 immediately and the target word unchanged.
